// File: rtl/shadow_gpr_snapshot_streamer.sv
// Captures all 32 shadow registers on request, then streams the masked ones out
// as OUT_WIDTH beats over a valid/ready master port.
module shadow_gpr_snapshot_streamer #(
  parameter int unsigned REGISTER_WIDTH = 128,
  parameter int unsigned OUT_WIDTH      = 64,
  parameter int unsigned CNT_WIDTH      = 16,
  localparam int unsigned CHUNKS        = REGISTER_WIDTH / OUT_WIDTH,
  localparam int unsigned CIW           = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REGISTER_WIDTH-1:0] registers_in [32],
  input  logic                      snapshot_request,
  input  logic [31:0]               reg_mask,
  output logic [OUT_WIDTH-1:0]      m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic [4:0]                m_reg_index,
  output logic [CIW-1:0]            m_chunk_index,
  output logic                      busy,
  output logic                      snapshot_done,
  output logic [CNT_WIDTH-1:0]      dropped_count
);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  localparam logic [CIW-1:0] LastChunk = CIW'(CHUNKS - 1);

  state_e                    state_q;
  logic [REGISTER_WIDTH-1:0] snap_q [32];
  // Mask bits still to be sent, excluding the register currently on the bus.
  logic [31:0]               pending_q;
  logic [4:0]                reg_idx_q;
  logic [CIW-1:0]            chunk_q;
  logic [CNT_WIDTH-1:0]      dropped_q;

  function automatic logic [4:0] lowest_set(input logic [31:0] m);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      reg_idx_q <= '0;
      chunk_q   <= '0;
      dropped_q <= '0;
      for (int i = 0; i < 32; i++) snap_q[i] <= '0;
    end else begin
      if (snapshot_request && (state_q != StIdle) && (dropped_q != '1)) begin
        dropped_q <= dropped_q + CNT_WIDTH'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (snapshot_request) begin
            for (int i = 0; i < 32; i++) snap_q[i] <= registers_in[i];
            reg_idx_q <= lowest_set(reg_mask);
            pending_q <= reg_mask & (reg_mask - 32'd1);
            chunk_q   <= '0;
            state_q   <= (reg_mask != '0) ? StStream : StDone;
          end
        end
        StStream: begin
          if (m_tready) begin
            if (chunk_q == LastChunk) begin
              chunk_q <= '0;
              if (pending_q == '0) begin
                state_q <= StDone;
              end else begin
                reg_idx_q <= lowest_set(pending_q);
                pending_q <= pending_q & (pending_q - 32'd1);
              end
            end else begin
              chunk_q <= chunk_q + CIW'(1);
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [REGISTER_WIDTH-1:0] cur_reg;

  always_comb begin
    cur_reg = snap_q[reg_idx_q];
    m_tdata = '0;
    if (state_q == StStream) m_tdata = cur_reg[32'(chunk_q) * OUT_WIDTH +: OUT_WIDTH];
  end

  assign m_tvalid      = (state_q == StStream);
  assign m_tlast       = m_tvalid && (chunk_q == LastChunk) && (pending_q == '0);
  assign m_reg_index   = reg_idx_q;
  assign m_chunk_index = chunk_q;
  assign busy          = (state_q != StIdle);
  assign snapshot_done = (state_q == StDone);
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_shadow_gpr_snapshot_streamer.sv
// Directed bench for the snapshot streamer: ordering, stalls, empty mask,
// same-edge coherence, dropped-request saturation and mid-stream reset.
module tb_shadow_gpr_snapshot_streamer;

  localparam int unsigned RW = 128;
  localparam int unsigned OW = 64;
  localparam int unsigned CW = 16;
  localparam logic [127:0] X1 = {64'h1111111111111111, 64'h2222222222222222};
  localparam logic [127:0] X2 = {64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB};
  localparam logic [127:0] X1New = {64'h5555555555555555, 64'h6666666666666666};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] regs [32];
  logic          req;
  logic [31:0]   mask;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [4:0]    m_reg_index;
  logic [0:0]    m_chunk_index;
  logic          busy, snapshot_done;
  logic [CW-1:0] dropped_count;

  logic          load_all, wr_en;
  logic [4:0]    wr_idx;
  logic [RW-1:0] wr_val;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_d [4];
  logic [4:0]  exp_i [4];
  logic [0:0]  exp_c [4];

  always #5 clk = ~clk;

  shadow_gpr_snapshot_streamer #(
    .REGISTER_WIDTH(RW),
    .OUT_WIDTH     (OW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .registers_in    (regs),
    .snapshot_request(req),
    .reg_mask        (mask),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast),
    .m_reg_index     (m_reg_index),
    .m_chunk_index   (m_chunk_index),
    .busy            (busy),
    .snapshot_done   (snapshot_done),
    .dropped_count   (dropped_count)
  );

  function automatic logic [127:0] reg_init(input int i);
    if (i == 1) return X1;
    if (i == 2) return X2;
    return {64'hC0DE_0000_0000_0000 + 64'(2 * i + 1), 64'hC0DE_0000_0000_0000 + 64'(2 * i)};
  endfunction

  // Shadow register file model: writes land on the clock edge.
  always @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < 32; i++) regs[i] <= reg_init(i);
    end else if (wr_en) begin
      regs[wr_idx] <= wr_val;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({m_tvalid, m_tlast, busy, snapshot_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {m_tvalid, m_tlast, busy, snapshot_done});
    end
    n_tests++;
    if ({m_tdata, m_reg_index, m_chunk_index, dropped_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h want 0", m_tdata, m_reg_index, m_chunk_index,
               dropped_count);
    end
  endtask

  task automatic test_basic();
    mask = 32'h6; m_tready = 1'b1; req = 1'b1;
    step();
    req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_tests++;
      if ({m_tvalid, m_tlast, m_reg_index, m_chunk_index, m_tdata} !==
          {1'b1, (b == 3), exp_i[b], exp_c[b], exp_d[b]}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got v=%b l=%b i=%0d c=%0d d=%h want v=1 l=%b i=%0d c=%0d d=%h",
                 b, m_tvalid, m_tlast, m_reg_index, m_chunk_index, m_tdata, (b == 3), exp_i[b],
                 exp_c[b], exp_d[b]);
      end
      step();
    end
    n_tests++;
    if ({snapshot_done, m_tvalid, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL basic_done: got done/valid/busy=%b want 101", {snapshot_done, m_tvalid, busy});
    end
    step();
    n_tests++;
    if ({snapshot_done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_idle: got done/busy=%b want 00", {snapshot_done, busy});
    end
  endtask

  task automatic test_stall();
    logic [15:0] pat;
    logic [71:0] held_v;
    logic [71:0] cur;
    bit          held;
    int          k;
    int          dones;
    pat = 16'b1111_1111_1110_1001;
    held = 1'b0; k = 0; dones = 0; held_v = '0;
    mask = 32'h6; m_tready = 1'b0; req = 1'b1;
    step();
    req = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cur = {m_tlast, m_reg_index, m_chunk_index, m_tdata, 1'b0};
      if (snapshot_done) dones++;
      if (m_tvalid) begin
        if (held) begin
          n_tests++;
          if (cur !== held_v) begin
            n_fail++;
            $display("FAIL stall_hold_c%0d: got %h want %h", c, cur, held_v);
          end
        end
        m_tready = pat[c];
        if (m_tready) begin
          n_tests++;
          if (k >= 4) begin
            n_fail++;
            $display("FAIL stall_extra_beat: got beat %0d want at most 4 beats", k);
          end else if ({m_tlast, m_reg_index, m_chunk_index, m_tdata} !==
                       {(k == 3), exp_i[k], exp_c[k], exp_d[k]}) begin
            n_fail++;
            $display("FAIL stall_beat%0d: got l=%b i=%0d c=%0d d=%h want i=%0d c=%0d d=%h", k,
                     m_tlast, m_reg_index, m_chunk_index, m_tdata, exp_i[k], exp_c[k], exp_d[k]);
          end
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_v = cur;
        end
      end
      step();
    end
    m_tready = 1'b1;
    n_tests++;
    if (k != 4 || dones != 1) begin
      n_fail++;
      $display("FAIL stall_count: got beats=%0d dones=%0d want beats=4 dones=1", k, dones);
    end
  endtask

  task automatic test_mask0();
    mask = 32'h0; req = 1'b1;
    step();
    req = 1'b0;
    n_tests++;
    if ({m_tvalid, snapshot_done, busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL mask0_n1: got valid/done/busy=%b want 011", {m_tvalid, snapshot_done, busy});
    end
    step();
    n_tests++;
    if ({m_tvalid, snapshot_done, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL mask0_n2: got valid/done/busy=%b want 000", {m_tvalid, snapshot_done, busy});
    end
  endtask

  task automatic test_coherence();
    mask = 32'h2; m_tready = 1'b1; req = 1'b1;
    wr_en = 1'b1; wr_idx = 5'd1; wr_val = X1New;
    step();
    req = 1'b0; wr_en = 1'b0;
    n_tests++;
    if ({m_tvalid, m_tdata} !== {1'b1, X1[63:0]}) begin
      n_fail++;
      $display("FAIL coherence_lo: got v=%b d=%h want v=1 d=%h", m_tvalid, m_tdata, X1[63:0]);
    end
    step();
    n_tests++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, X1[127:64]}) begin
      n_fail++;
      $display("FAIL coherence_hi: got v=%b l=%b d=%h want v=1 l=1 d=%h", m_tvalid, m_tlast,
               m_tdata, X1[127:64]);
    end
    step();
    step();
    wr_en = 1'b1; wr_val = X1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_dropped();
    mask = 32'h6; m_tready = 1'b0; req = 1'b1;
    step();
    repeat (3) step();
    req = 1'b0;
    n_tests++;
    if (dropped_count !== 16'd3) begin
      n_fail++;
      $display("FAIL dropped_stream: got %0d want 3", dropped_count);
    end
    m_tready = 1'b1;
    repeat (4) step();
    n_tests++;
    if (snapshot_done !== 1'b1) begin
      n_fail++;
      $display("FAIL dropped_in_done: got done=%b want 1", snapshot_done);
    end
    req = 1'b1;
    step();
    req = 1'b0;
    n_tests++;
    if ({dropped_count, busy} !== {16'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL dropped_total: got %0d busy=%b want 4 busy=0", dropped_count, busy);
    end
    step();
  endtask

  task automatic test_saturate_and_reset();
    logic [127:0] r;
    logic [63:0]  ed;
    mask = 32'hFFFF_FFFF; m_tready = 1'b0; req = 1'b1;
    repeat (70000) step();
    req = 1'b0;
    n_tests++;
    if ({dropped_count, busy} !== {16'hFFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL saturate: got %h busy=%b want ffff busy=1", dropped_count, busy);
    end
    m_tready = 1'b1;
    repeat (10) step();
    n_tests++;
    if ({m_tvalid, m_reg_index, m_chunk_index} !== {1'b1, 5'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL pre_reset_beat11: got v=%b i=%0d c=%0d want v=1 i=5 c=0", m_tvalid,
               m_reg_index, m_chunk_index);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++;
    if ({m_tvalid, m_tlast, busy, snapshot_done, dropped_count} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b l=%b busy=%b done=%b drop=%h want all 0", m_tvalid,
               m_tlast, busy, snapshot_done, dropped_count);
    end
    step();
    n_tests++;
    if ({m_tvalid, snapshot_done, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got valid/done/busy=%b want 000",
               {m_tvalid, snapshot_done, busy});
    end
    req = 1'b1;
    step();
    req = 1'b0;
    for (int b = 0; b < 64; b++) begin
      r = reg_init(b / 2);
      ed = r[(b % 2) * 64 +: 64];
      n_tests++;
      if ({m_tvalid, m_tlast, m_reg_index, m_chunk_index, m_tdata} !==
          {1'b1, (b == 63), 5'(b / 2), 1'(b % 2), ed}) begin
        n_fail++;
        $display("FAIL full_beat%0d: got v=%b l=%b i=%0d c=%0d d=%h want i=%0d c=%0d d=%h", b,
                 m_tvalid, m_tlast, m_reg_index, m_chunk_index, m_tdata, b / 2, b % 2, ed);
      end
      step();
    end
    n_tests++;
    if ({snapshot_done, m_tvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_done: got done/valid=%b want 10", {snapshot_done, m_tvalid});
    end
    step();
  endtask

  initial begin
    exp_d[0] = 64'h2222222222222222; exp_i[0] = 5'd1; exp_c[0] = 1'b0;
    exp_d[1] = 64'h1111111111111111; exp_i[1] = 5'd1; exp_c[1] = 1'b1;
    exp_d[2] = 64'hBBBBBBBBBBBBBBBB; exp_i[2] = 5'd2; exp_c[2] = 1'b0;
    exp_d[3] = 64'hAAAAAAAAAAAAAAAA; exp_i[3] = 5'd2; exp_c[3] = 1'b1;
    rst_n = 1'b0; req = 1'b0; mask = '0; m_tready = 1'b0;
    load_all = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_val = '0;
    step();
    step();
    load_all = 1'b0;
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_stall();
    test_mask0();
    test_coherence();
    test_dropped();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
